pcm_serial_rx: RTL and testbench

PCM_SERIAL_RX -- requirements
Module: pcm_serial_rx

---
 rtl/pcm_serial_rx.sv | 159 +++++++++++++++
 tb/tb_pcm_serial_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_serial_rx.sv
// PCM serial receiver: deserialises MSB-first 16-bit linear PCM words framed by a
// short fsync pulse and queues them in a small FIFO for the downstream compressor.
module pcm_serial_rx #(
  parameter int unsigned DEPTH = 4,  // FIFO depth in words, power of two, 2..16
  parameter int unsigned LVLW  = 3   // log2(DEPTH)+1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bit_en,
  input  logic            fsync,
  input  logic            sdin,
  output logic [15:0]     pcm_data,
  output logic            pcm_valid,
  input  logic            pcm_ready,
  output logic [LVLW-1:0] fifo_level,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic            frame_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Deserialiser state
  state_e      state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  // Only the first 15 bits need storing; the 16th comes straight from sdin.
  logic [14:0] sreg_q, sreg_d;
  logic        frame_err_q, frame_err_d;
  logic        word_push;
  logic [15:0] word;

  // FIFO state
  logic [15:0]     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            drop;

  // Frame FSM: next state, bit counter, shift register, word completion and framing error
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    sreg_d      = sreg_q;
    frame_err_d = 1'b0;
    word_push   = 1'b0;
    word        = {sreg_q, sdin};
    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (fsync) begin
            state_d = StShift;
            bcnt_d  = 4'd0;
            sreg_d  = '0;
          end
        end
        StShift: begin
          if (bcnt_q == 4'd15) begin
            // Last bit completes the word even when fsync arrives with it;
            // that fsync then opens the next frame immediately.
            word_push = 1'b1;
            bcnt_d    = 4'd0;
            sreg_d    = '0;
            state_d   = fsync ? StShift : StIdle;
          end else if (fsync) begin
            // Early sync: drop the partial word and resynchronise on this pulse.
            frame_err_d = 1'b1;
            bcnt_d      = 4'd0;
            sreg_d      = '0;
          end else begin
            sreg_d = {sreg_q[13:0], sdin};
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bcnt_q      <= 4'd0;
      sreg_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sreg_q      <= sreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign full      = (count_q == LVLW'(DEPTH));
  assign pcm_valid = (count_q != '0);
  assign pop       = pcm_valid & pcm_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en     = word_push & (~full | pop);
  assign drop      = word_push & full & ~pop;

  // FIFO pointer, occupancy and sticky overrun next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new drop beats a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents are only observable through valid-gated pcm_data
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= word;
    end
  end

  assign pcm_data   = pcm_valid ? mem[rd_ptr_q] : 16'h0000;
  assign fifo_level = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pcm_serial_rx.sv
// Randomised + directed bench for pcm_serial_rx, checked against a frame/queue model.
module tb_pcm_serial_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVLW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            bit_en, fsync, sdin;
  logic [15:0]     pcm_data;
  logic            pcm_valid, pcm_ready;
  logic [LVLW-1:0] fifo_level;
  logic            overrun, ovr_clr, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rnd = 1'b0;
  int gap_max = 0;
  int ready_pct = 50;

  // Behavioural model: frame position, value accumulated so far, FIFO as a queue.
  logic [15:0] m_q[$];
  bit          m_in_frame;
  int          m_nbits;
  int          m_val;
  bit          m_ovr;
  bit          m_ferr;
  bit          m_pop, m_push, m_set;
  int          m_sz;
  logic [15:0] m_word;

  always #5 clk = ~clk;

  pcm_serial_rx #(.DEPTH(DEPTH), .LVLW(LVLW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .fsync      (fsync),
    .sdin       (sdin),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_in_frame = 1'b0;
      m_nbits    = 0;
      m_val      = 0;
      m_ovr      = 1'b0;
      m_ferr     = 1'b0;
    end else begin
      m_sz   = m_q.size();
      m_pop  = (m_sz > 0) && pcm_ready;
      m_push = 1'b0;
      m_set  = 1'b0;
      m_ferr = 1'b0;
      m_word = '0;
      if (bit_en) begin
        if (!m_in_frame) begin
          if (fsync) begin
            m_in_frame = 1'b1;
            m_nbits = 0;
            m_val = 0;
          end
        end else if (m_nbits == 15) begin
          m_word = 16'((m_val * 2 + int'(sdin)) % 65536);
          m_push = 1'b1;
          m_in_frame = fsync;
          m_nbits = 0;
          m_val = 0;
        end else if (fsync) begin
          m_ferr = 1'b1;
          m_nbits = 0;
          m_val = 0;
        end else begin
          m_val = m_val * 2 + int'(sdin);
          m_nbits++;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_sz < DEPTH || m_pop) m_q.push_back(m_word);
        else m_set = 1'b1;
      end
      if (m_set) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 32'(pcm_valid), 32'(m_q.size() > 0));
      check("cyc_level", 32'(fifo_level), 32'(m_q.size()));
      if (m_q.size() > 0) check("cyc_data", 32'(pcm_data), 32'(m_q[0]));
      check("cyc_overrun", 32'(overrun), 32'(m_ovr));
      check("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      pcm_ready = ($urandom_range(0, 99) < ready_pct);
      ovr_clr   = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic drive_bit(input logic f, input logic d);
    bit_en = 1'b1;
    fsync  = f;
    sdin   = d;
    tick();
    bit_en = 1'b0;
    fsync  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    sdin   = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  // Send the top n bits of w, MSB first; optional fsync on the last one.
  task automatic send_bits(input logic [15:0] w, input int n, input bit last_fs);
    for (int i = 0; i < n; i++) begin
      drive_bit((i == n - 1) ? last_fs : 1'b0, w[15 - i]);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input bit last_fs);
    drive_bit(1'b1, 1'($urandom_range(0, 1)));
    send_bits(w, 16, last_fs);
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b0;
    bit_en = 1'b0; fsync = 1'b0; sdin = 1'b0; pcm_ready = 1'b0; ovr_clr = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_valid", 32'(pcm_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_data", 32'(pcm_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    tick();

    // Single frame with downstream ready
    pcm_ready = 1'b1;
    send_frame(16'hA5C3, 1'b0);
    check("single_valid", 32'(pcm_valid), 1);
    check("single_data", 32'(pcm_data), 32'h0000A5C3);
    check("single_level", 32'(fifo_level), 1);
    check("single_model_level", 32'(m_q.size()), 1);
    tick();
    check("single_valid_after", 32'(pcm_valid), 0);
    check("single_level_after", 32'(fifo_level), 0);

    // Fill past capacity, then drain
    pcm_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(16'(k), 1'b0);
      if (k == 4) check("fill_ovr_before", 32'(overrun), 0);
    end
    check("fill_level", 32'(fifo_level), 4);
    check("fill_overrun", 32'(overrun), 1);
    check("fill_model_ovr", 32'(m_ovr), 1);
    pcm_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_data", 32'(pcm_data), 32'(k));
      tick();
    end
    pcm_ready = 1'b0;
    check("drain_level", 32'(fifo_level), 0);
    check("drain_ovr_sticky", 32'(overrun), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);

    // Full FIFO, fifth word completes on a popping edge
    for (int k = 11; k <= 14; k++) send_frame(16'(k), 1'b0);
    check("full_level", 32'(fifo_level), 4);
    drive_bit(1'b1, 1'b0);
    send_bits(16'd15, 15, 1'b0);
    pcm_ready = 1'b1;
    drive_bit(1'b0, 1'b1);
    pcm_ready = 1'b0;
    check("fullpop_level", 32'(fifo_level), 4);
    check("fullpop_overrun", 32'(overrun), 0);
    pcm_ready = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      check("fullpop_data", 32'(pcm_data), 32'(k));
      tick();
    end
    pcm_ready = 1'b0;

    // Truncated frame: early fsync resynchronises
    drive_bit(1'b1, 1'b0);
    send_bits(16'hFFFF, 9, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("trunc_frame_err", 32'(frame_err), 1);
    check("trunc_level", 32'(fifo_level), 0);
    tick();
    check("trunc_pulse_end", 32'(frame_err), 0);
    send_bits(16'h7FFF, 16, 1'b0);
    check("trunc_next_level", 32'(fifo_level), 1);
    check("trunc_next_data", 32'(pcm_data), 32'h00007FFF);
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;

    // Back-to-back frames sharing the sync bit
    send_frame(16'h8000, 1'b1);
    send_bits(16'h1234, 16, 1'b0);
    check("b2b_level", 32'(fifo_level), 2);
    check("b2b_data0", 32'(pcm_data), 32'h00008000);
    pcm_ready = 1'b1;
    tick();
    check("b2b_data1", 32'(pcm_data), 32'h00001234);
    tick();
    pcm_ready = 1'b0;

    // Reset mid-frame with stored words
    send_frame(16'h1111, 1'b0);
    send_frame(16'h2222, 1'b0);
    check("mid_level", 32'(fifo_level), 2);
    drive_bit(1'b1, 1'b0);
    send_bits(16'hABCD, 8, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(pcm_valid), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_data", 32'(pcm_data), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    tick();
    reset = 1'b0;
    send_bits(16'hFFFF, 8, 1'b0);
    send_frame(16'h3C3C, 1'b0);
    check("post_rst_level", 32'(fifo_level), 1);
    check("post_rst_data", 32'(pcm_data), 32'h00003C3C);
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;

    // Randomised traffic
    rnd = 1'b1;
    gap_max = 3;
    for (int it = 0; it < 60; it++) begin
      ready_pct = (it < 30) ? 20 : 70;
      w = 16'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: send_frame(w, 1'b0);
        3:       send_frame(w, 1'b1);
        4: begin
          drive_bit(1'b1, 1'b0);
          send_bits(w, $urandom_range(1, 15), 1'b0);
        end
        default: send_bits(w, $urandom_range(1, 6), 1'b0);
      endcase
    end
    rnd = 1'b0;
    ovr_clr = 1'b0;
    pcm_ready = 1'b1;
    repeat (20) tick();
    check("final_level", 32'(fifo_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
